// File: rtl/down_counter_timer_if.sv
// Load handshake and status bundle for down_counter_timer.
// The slave modport is the timer; the master modport is whoever drives it.
interface down_counter_timer_if #(
  parameter int unsigned MAX_VALUE = 255
);
  localparam int unsigned COUNTER_WIDTH = $clog2(MAX_VALUE + 1);

  logic                     load_valid_i;
  logic                     load_ready_o;
  logic [COUNTER_WIDTH-1:0] load_value_i;
  logic                     reload_i;
  logic                     enable_i;
  logic                     abort_i;
  logic [COUNTER_WIDTH-1:0] value_o;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  load_valid_i, load_value_i, reload_i, enable_i, abort_i,
    output load_ready_o, value_o, busy_o, done_o
  );

  modport master (
    output load_valid_i, load_value_i, reload_i, enable_i, abort_i,
    input  load_ready_o, value_o, busy_o, done_o
  );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload operation and a
// registered one-cycle done pulse at terminal count.
module down_counter_timer #(
  parameter int unsigned MAX_VALUE = 255
) (
  input  logic                 clk_i,
  input  logic                 s_rst_i,
  down_counter_timer_if.slave  bus
);
  localparam int unsigned COUNTER_WIDTH = $clog2(MAX_VALUE + 1);
  localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = COUNTER_WIDTH'(MAX_VALUE);
  localparam logic [COUNTER_WIDTH-1:0] ONE       = COUNTER_WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state;
  logic [COUNTER_WIDTH-1:0] value;
  logic [COUNTER_WIDTH-1:0] reload_value;
  logic                     auto_reload;
  logic                     busy;
  logic                     done;
  logic                     load_ready;
  logic [COUNTER_WIDTH-1:0] load_clamped;

  // Oversize requests saturate to MAX_VALUE rather than wrapping.
  always_comb begin
    load_clamped = bus.load_value_i;
    if (bus.load_value_i > MAX_COUNT) load_clamped = MAX_COUNT;
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state        <= IDLE;
      value        <= '0;
      reload_value <= '0;
      auto_reload  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid_i && load_ready) begin
            value        <= load_clamped;
            reload_value <= load_clamped;
            auto_reload  <= bus.reload_i;
            if (load_clamped != '0) begin
              state      <= RUN;
              busy       <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort wins over a coincident terminal edge, so no done pulse.
          if (bus.abort_i) begin
            state      <= IDLE;
            value      <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (bus.enable_i) begin
            if (value == ONE) begin
              done <= 1'b1;
              if (auto_reload) begin
                value <= reload_value;
              end else begin
                value      <= '0;
                state      <= IDLE;
                busy       <= 1'b0;
                load_ready <= 1'b1;
              end
            end else begin
              value <= value - ONE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          value      <= '0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.value_o      = value;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
  assign bus.load_ready_o = load_ready;
endmodule
